// File: rtl/wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_capture
// Purpose  : Captures retiring register writebacks (register index, data and
//            a 16-bit cycle stamp) into a small FIFO that a trace consumer
//            drains with a valid/ready handshake. A capture that arrives while
//            the FIFO is full and not being popped is dropped. Each drop sets a
//            sticky overflow flag and bumps a saturating drop counter.
// Ports    : clk, reset_n (sync, active-low)
//            trace_en, write_register_out_stage_5, write_data_stage_5,
//            RegWrite_out_stage_5       -- writeback observation
//            trace_valid, trace_ready, trace_reg, trace_data, trace_stamp
//                                       -- head-of-FIFO handshake
//            trace_count, overflow, drop_count -- status
// Params   : DEPTH -- FIFO entries, power of two (>= 2)
// Revision : 1.0  initial release
// ============================================================================
module wb_trace_capture #(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               trace_en,
   input  logic [4:0]         write_register_out_stage_5,
   input  logic signed [63:0] write_data_stage_5,
   input  logic               RegWrite_out_stage_5,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [4:0]         trace_reg,
   output logic signed [63:0] trace_data,
   output logic [15:0]        trace_stamp,
   output logic [3:0]         trace_count,
   output logic               overflow,
   output logic [7:0]         drop_count
);

   localparam int               c_aw      = $clog2(DEPTH);
   localparam logic [c_aw:0]    c_ptr_one = (c_aw+1)'(1);

   // Entry layout: {reg[84:80], data[79:16], stamp[15:0]}
   logic [84:0]     r_mem [DEPTH];
   logic [c_aw:0]   r_wr_ptr;
   logic [c_aw:0]   r_rd_ptr;
   logic [15:0]     r_stamp;
   logic            r_overflow;
   logic [7:0]      r_drop_count;

   logic            w_capture;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [84:0]     w_head;
   logic [c_aw:0]   w_occupancy;

   // Writes to x0 never produce a trace entry and never count as drops.
   assign w_capture = RegWrite_out_stage_5 && trace_en &&
                      (write_register_out_stage_5 != 5'd0);

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

   // Pop depends only on registered pointers plus ready, so trace_valid
   // itself never depends on trace_ready.
   assign w_pop  = !w_empty && trace_ready;
   // When full, a simultaneous pop frees the head slot. That slot is the one
   // the write pointer addresses, so the new entry lands there on the same edge.
   assign w_push = w_capture && (!w_full || w_pop);
   assign w_drop = w_capture && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_stamp      <= 16'd0;
         r_overflow   <= 1'b0;
         r_drop_count <= 8'd0;
      end else begin
         r_stamp <= r_stamp + 16'd1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
               r_drop_count <= r_drop_count + 8'd1;
            end
         end
      end
   end

   // Storage needs no reset: the pointers alone define which slots are live.
   // Writes are suppressed during reset so a capture in that cycle leaves no trace.
   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= {write_register_out_stage_5,
                                       write_data_stage_5, r_stamp};
      end
   end

   assign w_head      = r_mem[r_rd_ptr[c_aw-1:0]];
   assign w_occupancy = r_wr_ptr - r_rd_ptr;

   assign trace_valid = !w_empty;
   assign trace_reg   = w_empty ? 5'd0  : w_head[84:80];
   assign trace_data  = w_empty ? 64'sd0 : signed'(w_head[79:16]);
   assign trace_stamp = w_empty ? 16'd0 : w_head[15:0];
   assign trace_count = 4'(w_occupancy);
   assign overflow    = r_overflow;
   assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_trace_capture
// Purpose  : Self-checking bench for wb_trace_capture. It applies a directed
//            vector table, hand-written multi-cycle corner sequences, and a
//            long randomized run checked against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_trace_capture;

   localparam int DEPTH = 8;

   logic               clk;
   logic               reset_n;
   logic               trace_en;
   logic [4:0]         wreg;
   logic signed [63:0] wdata;
   logic               regwrite;
   logic               trace_valid;
   logic               trace_ready;
   logic [4:0]         trace_reg;
   logic signed [63:0] trace_data;
   logic [15:0]        trace_stamp;
   logic [3:0]         trace_count;
   logic               overflow;
   logic [7:0]         drop_count;

   int n_pass  = 0;
   int n_total = 0;

   wb_trace_capture #(.DEPTH(DEPTH)) dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .trace_en                   (trace_en),
      .write_register_out_stage_5 (wreg),
      .write_data_stage_5         (wdata),
      .RegWrite_out_stage_5       (regwrite),
      .trace_valid                (trace_valid),
      .trace_ready                (trace_ready),
      .trace_reg                  (trace_reg),
      .trace_data                 (trace_data),
      .trace_stamp                (trace_stamp),
      .trace_count                (trace_count),
      .overflow                   (overflow),
      .drop_count                 (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rg;
      logic [63:0] d;
      logic [15:0] st;
   } entry_t;

   entry_t      mq[$];
   logic [15:0] m_stamp = 16'd0;
   logic        m_ovf   = 1'b0;
   int          m_drops = 0;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic rn, input logic en, input logic we,
                        input logic [4:0] rg, input logic [63:0] d, input logic rdy);
      reset_n = rn; trace_en = en; regwrite = we; wreg = rg; wdata = d; trace_ready = rdy;
   endtask

   // Advances the model by the rules for the current inputs, then one clock.
   task automatic tick();
      entry_t e;
      if (!reset_n) begin
         mq.delete();
         m_stamp = 16'd0;
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         if (mq.size() > 0 && trace_ready) void'(mq.pop_front());
         if (regwrite && trace_en && wreg != 5'd0) begin
            if (mq.size() < DEPTH) begin
               e.rg = wreg; e.d = wdata; e.st = m_stamp;
               mq.push_back(e);
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
         m_stamp = m_stamp + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 64'(trace_valid), 64'(mq.size() != 0));
      chk({tag, ".count"}, 64'(trace_count), 64'(mq.size()));
      chk({tag, ".ovf"},   64'(overflow),    64'(m_ovf));
      chk({tag, ".drops"}, 64'(drop_count),  64'(m_drops));
      if (mq.size() != 0) begin
         chk({tag, ".reg"},   64'(trace_reg),   64'(mq[0].rg));
         chk({tag, ".data"},  trace_data,       mq[0].d);
         chk({tag, ".stamp"}, 64'(trace_stamp), 64'(mq[0].st));
      end else begin
         chk({tag, ".reg0"},   64'(trace_reg),   64'd0);
         chk({tag, ".data0"},  trace_data,       64'd0);
         chk({tag, ".stamp0"}, 64'(trace_stamp), 64'd0);
      end
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rn, en, we;
      logic [4:0]  rg;
      logic [63:0] d;
      logic        rdy;
      logic        e_valid;
      logic [4:0]  e_reg;
      logic [63:0] e_data;
      logic [15:0] e_stamp;
      logic [3:0]  e_count;
      logic        e_ovf;
      logic [7:0]  e_drops;
   } vec_t;

   localparam logic [63:0] c_m32 = 64'hFFFF_FFFF_FFFF_FFE0;

   vec_t vt[11];

   initial begin
      logic [63:0] dv;
      logic [4:0]  er;
      int          chunk_rdy_pct;

      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);

      //          rn    en    we    reg    data     rdy  | valid reg   data   stamp  cnt   ovf   drops
      vt[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[2]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[3]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[6]  = '{1'b1, 1'b1, 1'b1, 5'd2, c_m32,  1'b0, 1'b1, 5'd2, c_m32, 16'd5, 4'd1, 1'b0, 8'd0};
      vt[7]  = '{1'b1, 1'b1, 1'b1, 5'd0, 64'd19, 1'b0, 1'b1, 5'd2, c_m32, 16'd5, 4'd1, 1'b0, 8'd0};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[9]  = '{1'b1, 1'b1, 1'b1, 5'd0, 64'd19, 1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};
      vt[10] = '{1'b1, 1'b0, 1'b1, 5'd7, 64'd5,  1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 4'd0, 1'b0, 8'd0};

      for (int i = 0; i < 11; i++) begin
         drive(vt[i].rn, vt[i].en, vt[i].we, vt[i].rg, vt[i].d, vt[i].rdy);
         tick();
         chk($sformatf("vec%0d.valid", i), 64'(trace_valid), 64'(vt[i].e_valid));
         chk($sformatf("vec%0d.reg", i),   64'(trace_reg),   64'(vt[i].e_reg));
         chk($sformatf("vec%0d.data", i),  trace_data,       vt[i].e_data);
         chk($sformatf("vec%0d.stamp", i), 64'(trace_stamp), 64'(vt[i].e_stamp));
         chk($sformatf("vec%0d.count", i), 64'(trace_count), 64'(vt[i].e_count));
         chk($sformatf("vec%0d.ovf", i),   64'(overflow),    64'(vt[i].e_ovf));
         chk($sformatf("vec%0d.drops", i), 64'(drop_count),  64'(vt[i].e_drops));
      end

      // ---- 10 captures with no consumer: 8 kept, 2 dropped, drained in order
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b1, 5'(i + 1), 64'(i * 1000 - 3), 1'b0);
         tick();
         check_model("fill10");
      end
      chk("fill10.count8", 64'(trace_count), 64'd8);
      chk("fill10.ovf1",   64'(overflow),    64'd1);
      chk("fill10.drops2", 64'(drop_count),  64'd2);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1);
         dv = 64'(i * 1000 - 3);
         chk("drain.reg",  64'(trace_reg), 64'(i + 1));
         chk("drain.data", trace_data,     dv);
         tick();
         check_model("drain");
      end
      chk("drain.empty", 64'(trace_valid), 64'd0);
      chk("drain.ovf_sticky", 64'(overflow), 64'd1);

      // ---- full FIFO with simultaneous capture and pop
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b1, 5'(i + 1), 64'(50 + i), 1'b0);
         tick();
      end
      chk("fullpp.pre_count", 64'(trace_count), 64'd8);
      drive(1'b1, 1'b1, 1'b1, 5'd20, 64'd777, 1'b1);
      chk("fullpp.head_before", 64'(trace_reg), 64'd1);
      tick();
      chk("fullpp.count", 64'(trace_count), 64'd8);
      chk("fullpp.ovf",   64'(overflow),    64'd0);
      chk("fullpp.head",  64'(trace_reg),   64'd2);
      check_model("fullpp");
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1);
         er = (i < 7) ? 5'(i + 2) : 5'd20;
         chk("fullpp.drain_reg", 64'(trace_reg), 64'(er));
         tick();
         check_model("fullpp.drain");
      end

      // ---- reset mid-stream with 3 entries queued and overflow set
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, 1'b1, 5'(i + 3), 64'(i), 1'b0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1);
         tick();
      end
      chk("midrst.pre_count", 64'(trace_count), 64'd3);
      chk("midrst.pre_ovf",   64'(overflow),    64'd1);
      drive(1'b0, 1'b1, 1'b1, 5'd9, 64'd123, 1'b1);
      tick();
      chk("midrst.valid", 64'(trace_valid), 64'd0);
      chk("midrst.count", 64'(trace_count), 64'd0);
      chk("midrst.ovf",   64'(overflow),    64'd0);
      chk("midrst.drops", 64'(drop_count),  64'd0);
      drive(1'b1, 1'b1, 1'b1, 5'd4, 64'd55, 1'b0);
      tick();
      chk("midrst.first_valid", 64'(trace_valid), 64'd1);
      chk("midrst.first_reg",   64'(trace_reg),   64'd4);
      chk("midrst.first_stamp", 64'(trace_stamp), 64'd0);
      check_model("midrst");

      // ---- 300 drops saturate drop_count
      do_reset();
      for (int i = 0; i < 308; i++) begin
         drive(1'b1, 1'b1, 1'b1, 5'(1 + (i % 31)), 64'(i), 1'b0);
         tick();
      end
      chk("sat.drops", 64'(drop_count),  64'd255);
      chk("sat.ovf",   64'(overflow),    64'd1);
      chk("sat.count", 64'(trace_count), 64'd8);
      check_model("sat");

      // ---- long randomized run; long enough for the stamp to wrap
      chunk_rdy_pct = 50;
      for (int c = 0; c < 66000; c++) begin
         if (c % 400 == 0) chunk_rdy_pct = $urandom_range(5, 95);
         drive(1'b1,
               ($urandom_range(0, 99) < 90),
               ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               {$urandom, $urandom},
               ($urandom_range(0, 99) < chunk_rdy_pct));
         tick();
         check_model("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
